// File: rtl/regfile_scoreboard_if.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard_if
// Bundles the register-file traffic between issue/writeback and the
// register file with its busy scoreboard.
//   rs1_addr/rs2_addr  : read addresses           (master -> slave)
//   rs1_data/rs2_data  : read data, combinational (slave -> master)
//   rs1_busy/rs2_busy  : source has a pending producer (slave -> master)
//   iss_en/iss_addr    : mark destination busy at issue (master -> slave)
//   wb_en/wb_addr/wb_data : writeback of a result  (master -> slave)
//   flush              : clear every busy bit      (master -> slave)
//   busy_vec           : registered scoreboard     (slave -> master)
//   dbg_reg            : committed debug register  (slave -> master)
// ---------------------------------------------------------------------------
interface regfile_scoreboard_if #(
    parameter int XLEN = 64,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG)
);
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            rs1_busy;
    logic            rs2_busy;
    logic            iss_en;
    logic [AW-1:0]   iss_addr;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic [NREG-1:0] busy_vec;
    logic [XLEN-1:0] dbg_reg;

    modport master (
        output rs1_addr, rs2_addr, iss_en, iss_addr,
               wb_en, wb_addr, wb_data, flush,
        input  rs1_data, rs2_data, rs1_busy, rs2_busy, busy_vec, dbg_reg
    );

    modport slave (
        input  rs1_addr, rs2_addr, iss_en, iss_addr,
               wb_en, wb_addr, wb_data, flush,
        output rs1_data, rs2_data, rs1_busy, rs2_busy, busy_vec, dbg_reg
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard
// Integer register file with two combinational read ports, one writeback
// port, optional same-cycle write-to-read bypass and a per-register busy
// scoreboard for hazard detection. Register 0 is hardwired to zero.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset, clears registers and busy bits
//   bus    : regfile_scoreboard_if.slave (read, issue, writeback, flush,
//            busy_vec, dbg_reg)
// ---------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int  XLEN    = 64,
    parameter int  NREG    = 32,
    parameter int  BYPASS  = 1,
    parameter int  DBG_IDX = 10,
    localparam int AW      = $clog2(NREG)
) (
    input logic                 clk,
    input logic                 rst_n,
    regfile_scoreboard_if.slave bus
);

    localparam logic [AW-1:0]   ZERO_A = {AW{1'b0}};
    localparam logic [AW-1:0]   DBG_A  = AW'(DBG_IDX);
    localparam logic            BYP_EN = (BYPASS != 32'sd0);
    localparam logic [NREG-1:0] ONE_V  = {{(NREG-1){1'b0}}, 1'b1};

    logic [XLEN-1:0] regs_q [NREG];
    logic [XLEN-1:0] regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] clr_mask_s;
    logic [NREG-1:0] set_mask_s;
    logic            rs1_hit_s;
    logic            rs2_hit_s;

    // Next register contents: writeback to any register except x0
    always_comb begin
        regs_d = regs_q;
        if (bus.wb_en && (bus.wb_addr != ZERO_A)) begin
            regs_d[bus.wb_addr] = bus.wb_data;
        end else begin
            regs_d = regs_q;
        end
        regs_d[0] = {XLEN{1'b0}};
    end

    // Next scoreboard: flush/writeback clear first, then issue sets, so a
    // new producer always supersedes a completing one; bit 0 never set
    always_comb begin
        clr_mask_s = bus.flush ? {NREG{1'b1}}
                   : (bus.wb_en ? (ONE_V << bus.wb_addr) : {NREG{1'b0}});
        set_mask_s = bus.iss_en ? (ONE_V << bus.iss_addr) : {NREG{1'b0}};
        busy_d     = ((busy_q & ~clr_mask_s) | set_mask_s) & ~ONE_V;
    end

    // State register: register array and scoreboard, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
            busy_q <= {NREG{1'b0}};
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    // Read ports: bypass is gated by rst_n so reads return 0 during reset
    // even while a writeback is being presented
    always_comb begin
        rs1_hit_s = BYP_EN && rst_n && bus.wb_en &&
                    (bus.wb_addr == bus.rs1_addr) && (bus.rs1_addr != ZERO_A);
        rs2_hit_s = BYP_EN && rst_n && bus.wb_en &&
                    (bus.wb_addr == bus.rs2_addr) && (bus.rs2_addr != ZERO_A);
        if (rs1_hit_s) begin
            bus.rs1_data = bus.wb_data;
            bus.rs1_busy = 1'b0;
        end else begin
            bus.rs1_data = regs_q[bus.rs1_addr];
            bus.rs1_busy = busy_q[bus.rs1_addr];
        end
        if (rs2_hit_s) begin
            bus.rs2_data = bus.wb_data;
            bus.rs2_busy = 1'b0;
        end else begin
            bus.rs2_data = regs_q[bus.rs2_addr];
            bus.rs2_busy = busy_q[bus.rs2_addr];
        end
    end

    assign bus.busy_vec = busy_q;
    assign bus.dbg_reg  = regs_q[DBG_A];

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised integer register file for the pipelined core; successor to the single-cycle register file.
- Adds configurable width and depth, same-cycle write-to-read bypass, a per-register busy scoreboard for hazard detection, a pipeline flush, and an asynchronous active-low reset that clears all state.
- Sits between decode/issue (reads operands, marks destinations busy) and writeback (writes results, clears busy).

Parameters:
- XLEN, 64, register data width in bits.
- NREG, 32, number of architectural registers; must be a power of two, at least 2.
- AW, $clog2(NREG), register address width (derived; do not override).
- BYPASS, 1, 1 = a writeback in the same cycle is visible on the read ports; 0 = reads see only committed state.
- DBG_IDX, 10, index of the register driven on dbg_reg (a0 by default).

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rs1_addr  input  AW  read port 1 address.
- rs2_addr  input  AW  read port 2 address.
- rs1_data  output  XLEN  read port 1 data (combinational).
- rs2_data  output  XLEN  read port 2 data (combinational).
- rs1_busy  output  1  read port 1 source has a pending producer.
- rs2_busy  output  1  read port 2 source has a pending producer.
- iss_en  input  1  issue: mark iss_addr busy.
- iss_addr  input  AW  destination register of the issuing instruction.
- wb_en  input  1  writeback enable.
- wb_addr  input  AW  writeback destination.
- wb_data  input  XLEN  writeback data.
- flush  input  1  clear all busy bits; register contents are kept.
- busy_vec  output  NREG  registered scoreboard; bit 0 is always 0.
- dbg_reg  output  XLEN  committed content of register DBG_IDX.

Behaviour:
- Reset (rst_n=0, asynchronous): all registers go to 0 and all busy bits go to 0 immediately, with no clock edge required. During reset, rs*_data, dbg_reg and busy_vec read 0 and rs*_busy read 0. Reset asserted mid-operation discards any write or issue in that cycle.
- Register 0 is hardwired to zero. Writes to address 0 are ignored, issues to address 0 are ignored, reading address 0 returns 0 with busy 0, and bypass never applies to address 0.
- Write: on the rising edge, if wb_en=1 and wb_addr!=0, reg[wb_addr] is set to wb_data. The write is committed in the next cycle.
- Read, BYPASS=1: if wb_en=1, wb_addr==rsN_addr and rsN_addr!=0, then rsN_data=wb_data and rsN_busy=0. Otherwise rsN_data=reg[rsN_addr] and rsN_busy=busy[rsN_addr].
- Read, BYPASS=0: rsN_data=reg[rsN_addr] and rsN_busy=busy[rsN_addr], with no forwarding.
- Scoreboard update on the rising edge, per register i!=0, in increasing priority:
  - wb_en and wb_addr==i: busy[i] is cleared.
  - iss_en and iss_addr==i: busy[i] is set. An issue wins over a writeback to the same register in the same cycle, because a new producer supersedes the old one.
  - flush: the whole vector is cleared first, then the issue term is applied. Flush together with issue leaves only busy[iss_addr]=1.
- A writeback to a non-busy register is legal: the data is written and busy stays 0.
- An issue to an already-busy register is legal: busy stays 1, and there is no counting.
- dbg_reg reflects the committed value only, never bypassed data.
- Both read ports are fully independent. They may address the same register, and both may match a writeback simultaneously.
- No combinational path exists from iss_en or flush to the rs*_data outputs.

Test Plan:
- Reset and x0:
  - Drive rst_n low asynchronously between clock edges. Required: busy_vec=0 and all reads return 0 immediately.
  - Write 0xDEAD to x0 and issue to x0. Required: rs1_addr=0 still gives data 0 and busy 0.
- Write then read:
  - wb_en=1, wb_addr=5, wb_data=0x1234_5678_9ABC_DEF0 at edge k. Required: from cycle k+1, rs2_addr=5 returns that value and dbg_reg is unchanged.
  - Then write 0x42 to x10. Required: dbg_reg=0x42 from the next cycle.
- Bypass:
  - With BYPASS=1, in the same cycle as a wb to x7 with 0xAA, rs1_addr=7 and rs2_addr=7. Required: both ports read 0xAA with busy=0, while dbg_reg still shows the old value of x10.
  - Repeat with BYPASS=0. Required: both ports read the old value of x7.
- Scoreboard:
  - iss x3 at edge k. Required: busy_vec[3]=1 at k+1 and rs1_busy=1 for rs1_addr=3.
  - wb x3 at edge k+2. Required: busy clears at k+3.
  - Same-cycle iss x3 + wb x3. Required: busy_vec[3] stays 1 and the data is written.
- Flush:
  - Issue x1, x2 and x4 in successive cycles, then flush together with iss x9. Required: busy_vec = only bit 9 set (0x200), and register contents are unchanged.
- Parametrisation:
  - Instantiate with XLEN=32, NREG=16. Write all 15 nonzero registers with value = index*0x11111111 truncated to 32 bits, then read back through both ports. Required: all values match, and bit 0 of busy_vec is always 0.
